// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: streams NCOEF symmetric-half coefficients from a valid/ready
// source into the interpolator's c_we/c_addr/c_in write port, with a stall timeout,
// an abort path and busy/done/err status for the control plane.
// Optional feature macro: FIR_COEFF_LOADER_CHECKSUM_EN adds a CHECK state that
// compares one trailing checksum word against the running sum of the load.
module fir_coeff_loader #(
    parameter int unsigned ORD        = 255,
    parameter int unsigned COEFF_SIZE = 16,
    parameter int unsigned TIMEOUT    = 1024,
    localparam int unsigned NCOEF     = (ORD + 1) / 2,
    localparam int unsigned AW        = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [COEFF_SIZE-1:0] s_data,
    output logic                  s_ready,
    output logic                  c_we,
    output logic [AW-1:0]         c_addr,
    output logic [COEFF_SIZE-1:0] c_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] LastIdx = AW'(NCOEF - 1);
    localparam logic [TW-1:0] LastTmr = TW'(TIMEOUT - 1);

`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StLoad, StCheck, StDone, StErr} state_t;
`else
    typedef enum logic [2:0] {StIdle, StLoad, StDone, StErr} state_t;
`endif

    state_t                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  err_q, err_d;
    logic                  we_q, we_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [COEFF_SIZE-1:0] cin_q, cin_d;
    // fin_q marks DONE entry; done pulses the cycle after, i.e. after the final c_we
    logic                  fin_q, fin_d;
    logic                  done_q;
    logic                  accepting;
    logic                  beat;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    logic [COEFF_SIZE-1:0] sum_q, sum_d;
`endif

`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    assign accepting = (state_q == StLoad) || (state_q == StCheck);
`else
    assign accepting = (state_q == StLoad);
`endif

    // abort outranks a beat, so a word offered in the abort cycle is not taken
    assign s_ready = accepting && !abort;
    assign beat    = s_valid && s_ready;
    assign c_we    = we_q;
    assign c_addr  = addr_q;
    assign c_in    = cin_q;
    assign busy    = accepting || we_q;
    assign done    = done_q;
    assign err     = err_q;

    // Next-state, counters and write-port staging
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        cin_d   = cin_q;
        fin_d   = 1'b0;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start && !abort) begin
                    state_d = StLoad;
                    idx_d   = '0;
                    tmr_d   = '0;
                    err_d   = 1'b0;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (beat) begin
                    we_d   = 1'b1;
                    addr_d = idx_q;
                    cin_d  = s_data;
                    idx_d  = idx_q + AW'(1);
                    tmr_d  = '0;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + s_data;
                    if (idx_q == LastIdx) state_d = StCheck;
`else
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                        fin_d   = 1'b1;
                    end
`endif
                end else if (tmr_q == LastTmr) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
            StCheck: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (beat) begin
                    tmr_d = '0;
                    if (s_data == sum_q) begin
                        state_d = StDone;
                        fin_d   = 1'b1;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end else if (tmr_q == LastTmr) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State and output registers, cleared asynchronously by nrst
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            cin_q   <= '0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            cin_q   <= cin_d;
            fin_q   <= fin_d;
            done_q  <= fin_q;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader (ORD=255, COEFF_SIZE=16, TIMEOUT=16).
// Checksum scenarios are compiled in when FIR_COEFF_LOADER_CHECKSUM_EN is defined.
module tb_fir_coeff_loader;

    localparam int unsigned NC = 128;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic        abort;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        c_we;
    logic [6:0]  c_addr;
    logic [15:0] c_in;
    logic        busy;
    logic        done;
    logic        err;

    fir_coeff_loader #(
        .ORD        (255),
        .COEFF_SIZE (16),
        .TIMEOUT    (16)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .abort   (abort),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_in    (c_in),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] data;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          idx;
    logic [15:0] sum;

    always @(posedge clk) cyc++;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every c_we must match the oldest outstanding beat, one cycle later
    always @(negedge clk) begin
        if (nrst === 1'b1 && c_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected c_we", 32'(c_addr), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("c_addr", 32'(c_addr), 32'(e.addr));
                check("c_in", 32'(c_in), 32'(e.data));
                check("c_we latency", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic check_all_zero(string tag);
        check({tag, " s_ready"}, 32'(s_ready), 0);
        check({tag, " c_we"}, 32'(c_we), 0);
        check({tag, " c_addr"}, 32'(c_addr), 0);
        check({tag, " c_in"}, 32'(c_in), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " err"}, 32'(err), 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idx   = 0;
        sum   = '0;
        check("start busy", 32'(busy), 1);
        check("start s_ready", 32'(s_ready), 1);
        check("start err clear", 32'(err), 0);
    endtask

    // Offer one word (optionally after a one-cycle bubble); expectation pushed on acceptance
    task automatic drive_word(input logic [15:0] d, input bit gap);
        bit ok = 1'b0;
        if (gap) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_ready) begin
                sb.push_back('{addr: idx[6:0], data: d, at: cyc + 1});
                idx++;
                sum = sum + d;
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) check("beat accepted", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_checksum(input logic [15:0] d);
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("checksum accepted", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // After the last data word: done pulses one cycle after the final c_we
    task automatic finish_load();
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
        send_checksum(sum);
`else
        check("busy on final c_we", 32'(busy), 1);
`endif
        check("done not early", 32'(done), 0);
        @(posedge clk);
        #1;
        check("done pulse", 32'(done), 1);
        check("err after load", 32'(err), 0);
        check("busy after load", 32'(busy), 0);
        check("s_ready after load", 32'(s_ready), 0);
        @(posedge clk);
        #1;
        check("done one cycle", 32'(done), 0);
        check("all c_we seen", 32'(sb.size()), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        idx = 0; sum = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("idle s_ready", 32'(s_ready), 0);

        // Back-to-back load, data = index
        do_start();
        for (int i = 0; i < NC; i++) drive_word(16'(i), 1'b0);
        finish_load();

        // Random bubbles on s_valid
        do_start();
        for (int i = 0; i < NC; i++) drive_word(16'(i * 3 + 7), 1'($urandom_range(0, 1)));
        finish_load();

        // Stall timeout after 10 beats
        do_start();
        for (int i = 0; i < 10; i++) drive_word(16'(16'h0100 + i), 1'b0);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            check("no early timeout", 32'(err), 0);
        end
        check("still loading", 32'(s_ready), 1);
        @(posedge clk);
        #1;
        check("timeout err", 32'(err), 1);
        check("timeout s_ready", 32'(s_ready), 0);
        check("timeout busy", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("err sticky", 32'(err), 1);
        do_start();
        for (int i = 0; i < NC; i++) drive_word(16'(16'hA000 + i), 1'b0);
        finish_load();

        // Abort after 64 beats, with start and a word offered in the same cycle
        do_start();
        for (int i = 0; i < 64; i++) drive_word(16'(16'h4000 - i), 1'b0);
        abort = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = 16'hDEAD;
        @(negedge clk);
        check("abort blocks beat", 32'(s_ready), 0);
        @(posedge clk);
        #1;
        abort = 1'b0; start = 1'b0; s_valid = 1'b0;
        check("abort busy", 32'(busy), 0);
        check("abort err", 32'(err), 0);
        check("abort done", 32'(done), 0);
        check("abort ignores start", 32'(s_ready), 0);
        @(posedge clk);
        #1;
        check("abort no stray c_we", 32'(sb.size()), 0);

        // Asynchronous reset at beat 70
        do_start();
        for (int i = 0; i < 70; i++) drive_word(16'(16'h7000 + i), 1'b0);
        #1;
        nrst = 1'b0;
        #1;
        check_all_zero("async reset");
        sb.delete();
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        do_start();
        for (int i = 0; i < NC; i++) drive_word(16'(16'h3000 + i), 1'b0);
        finish_load();

`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
        // 128 x 0x0101 sums to 0x8080
        do_start();
        for (int i = 0; i < NC; i++) drive_word(16'h0101, 1'b0);
        send_checksum(16'h8080);
        @(posedge clk);
        #1;
        check("checksum done", 32'(done), 1);
        check("checksum err", 32'(err), 0);
        do_start();
        for (int i = 0; i < NC; i++) drive_word(16'h0101, 1'b0);
        send_checksum(16'h8081);
        check("bad checksum err", 32'(err), 1);
        check("bad checksum busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        check("bad checksum no done", 32'(done), 0);
        check("bad checksum queue", 32'(sb.size()), 0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
